// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_pkg
//  Description : Segment bit order, blank pattern and the 16 logical
//                (active-high) seven-segment patterns for hex digits 0-F.
//  Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

  // Segment vector layout: bit 6 = a (top) ... bit 0 = g (middle)
  typedef logic [6:0] seg_t;

  localparam int c_bit_a = 6;
  localparam int c_bit_b = 5;
  localparam int c_bit_c = 4;
  localparam int c_bit_d = 3;
  localparam int c_bit_e = 2;
  localparam int c_bit_f = 1;
  localparam int c_bit_g = 0;

  localparam seg_t c_seg_blank = 7'b0000000;

  // Logical patterns abcdefg, indexed by nibble value
  localparam seg_t c_seg_table [16] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011,  // 9
    7'b1110111,  // A
    7'b0011111,  // b
    7'b1001110,  // C
    7'b0111101,  // d
    7'b1001111,  // E
    7'b1000111   // F
  };

endpackage : seven_seg_pkg
`default_nettype wire

// File: rtl/seven_seg_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_decode
//  Description : Combinational nibble to logical segment decoder. In decimal
//                mode codes 10-15 are blanked and flagged on dp.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_decode
  import seven_seg_pkg::*;
#(
  parameter int HEX_MODE = 1
) (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg,
  output logic       o_dp
);

  generate
    if (HEX_MODE != 0) begin : g_hex
      // Every code has a glyph; dp never lit
      always_comb begin
        o_seg = c_seg_table[i_nibble];
        o_dp  = 1'b0;
      end
    end else begin : g_dec
      // Non-decimal codes show nothing and raise dp as an error flag
      always_comb begin
        o_seg = c_seg_blank;
        o_dp  = 1'b0;
        if (i_nibble < 4'd10) begin
          o_seg = c_seg_table[i_nibble];
        end else begin
          o_dp  = 1'b1;
        end
      end
    end
  endgenerate

endmodule : seven_seg_decode
`default_nettype wire

// File: rtl/seven_seg.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg
//  Description : Registered hex/decimal seven-segment driver with selectable
//                output polarity (common cathode / common anode).
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg
  import seven_seg_pkg::*;
#(
  parameter int ACTIVE_LOW = 0,
  parameter int HEX_MODE   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic w,
  input  logic x,
  input  logic y,
  input  logic z,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g,
  output logic dp
);

  // Inversion mask applied to every output when driving a common-anode part
  localparam logic c_inv = (ACTIVE_LOW != 0);

  logic [3:0] w_nibble;
  logic [6:0] w_seg_log;
  logic       w_dp_log;
  logic [6:0] w_seg_phys;
  logic       w_dp_phys;
  logic [6:0] r_seg;
  logic       r_dp;

  assign w_nibble = {w, x, y, z};

  seven_seg_decode #(
    .HEX_MODE (HEX_MODE)
  ) u_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_seg_log),
    .o_dp     (w_dp_log)
  );

  assign w_seg_phys = w_seg_log ^ {7{c_inv}};
  assign w_dp_phys  = w_dp_log ^ c_inv;

  // Capture the decoded nibble; reset forces every output to its dark level
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= c_seg_blank ^ {7{c_inv}};
      r_dp  <= c_inv;
    end else begin
      r_seg <= w_seg_phys;
      r_dp  <= w_dp_phys;
    end
  end

  assign a  = r_seg[c_bit_a];
  assign b  = r_seg[c_bit_b];
  assign c  = r_seg[c_bit_c];
  assign d  = r_seg[c_bit_d];
  assign e  = r_seg[c_bit_e];
  assign f  = r_seg[c_bit_f];
  assign g  = r_seg[c_bit_g];
  assign dp = r_dp;

endmodule : seven_seg
`default_nettype wire

// File: tb/tb_seven_seg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg
//  Description : Directed bench for seven_seg: default build, decimal-mode
//                build and common-anode build driven from shared inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic w = 1'b0, x = 1'b0, y = 1'b0, z = 1'b0;

  logic a0, b0, c0, d0, e0, f0, g0, dp0;
  logic a1, b1, c1, d1, e1, f1, g1, dp1;
  logic a2, b2, c2, d2, e2, f2, g2, dp2;

  int total  = 0;
  int passed = 0;

  // Hand-entered logical patterns abcdefg for codes 0..F
  logic [6:0] tbl [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  always #5 clk = ~clk;

  seven_seg #(.ACTIVE_LOW(0), .HEX_MODE(1)) u_hex (
    .clk(clk), .rst(rst), .w(w), .x(x), .y(y), .z(z),
    .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0), .dp(dp0)
  );

  seven_seg #(.ACTIVE_LOW(0), .HEX_MODE(0)) u_dec (
    .clk(clk), .rst(rst), .w(w), .x(x), .y(y), .z(z),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1), .dp(dp1)
  );

  seven_seg #(.ACTIVE_LOW(1), .HEX_MODE(1)) u_anode (
    .clk(clk), .rst(rst), .w(w), .x(x), .y(y), .z(z),
    .a(a2), .b(b2), .c(c2), .d(d2), .e(e2), .f(f2), .g(g2), .dp(dp2)
  );

  wire [7:0] out_hex   = {a0, b0, c0, d0, e0, f0, g0, dp0};
  wire [7:0] out_dec   = {a1, b1, c1, d1, e1, f1, g1, dp1};
  wire [7:0] out_anode = {a2, b2, c2, d2, e2, f2, g2, dp2};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // Present nibble/reset, then advance one rising edge and settle
  task automatic step(input logic [3:0] n, input logic r);
    {w, x, y, z} = n;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two cycles with N=8: dark outputs throughout
    step(4'd8, 1'b1);
    check("reset1_hex",   out_hex,   8'b0000000_0);
    check("reset1_anode", out_anode, 8'b1111111_1);
    step(4'd8, 1'b1);
    check("reset2_hex",   out_hex,   8'b0000000_0);
    check("reset2_dec",   out_dec,   8'b0000000_0);
    check("reset2_anode", out_anode, 8'b1111111_1);

    // First edge after release shows the 8
    step(4'd8, 1'b0);
    check("release_hex", out_hex, 8'b1111111_0);

    // Counting sweep 0..15, one code per edge
    for (int n = 0; n < 16; n++) begin
      step(n[3:0], 1'b0);
      check($sformatf("sweep_hex_%0d", n), out_hex, {tbl[n], 1'b0});
      check($sformatf("sweep_dec_%0d", n), out_dec,
            (n < 10) ? {tbl[n], 1'b0} : 8'b0000000_1);
      check($sformatf("sweep_anode_%0d", n), out_anode, ~{tbl[n], 1'b0});
    end

    // Spot values worked by hand
    step(4'd2, 1'b0);
    check("n2_hex", out_hex, 8'b1101101_0);
    step(4'hA, 1'b0);
    check("nA_hex", out_hex, 8'b1110111_0);

    // Wrap 15 -> 0 on consecutive edges
    step(4'd15, 1'b0);
    check("wrap_F", out_hex, 8'b1000111_0);
    step(4'd0, 1'b0);
    check("wrap_0", out_hex, 8'b1111110_0);

    // Decimal mode: error flag on 12, plain digit on 9
    step(4'd12, 1'b0);
    check("dec_12", out_dec, 8'b0000000_1);
    step(4'd9, 1'b0);
    check("dec_9", out_dec, 8'b1111011_0);

    // Common anode: digit 1
    step(4'd1, 1'b0);
    check("anode_1", out_anode, 8'b1001111_1);

    // Mid-stream reset pulse at N=5
    step(4'd3, 1'b0);
    check("mid_3", out_hex, 8'b1111001_0);
    step(4'd4, 1'b0);
    check("mid_4", out_hex, 8'b0110011_0);
    step(4'd5, 1'b1);
    check("mid_rst_hex",   out_hex,   8'b0000000_0);
    check("mid_rst_anode", out_anode, 8'b1111111_1);
    step(4'd6, 1'b0);
    check("mid_6", out_hex, 8'b1011111_0);
    step(4'd7, 1'b0);
    check("mid_7", out_hex, 8'b1110000_0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_seven_seg
`default_nettype wire

// File: doc/seven_seg.md
SEVEN_SEG -- requirements
Module: seven_seg

Interface
REQ-001 Parameter ACTIVE_LOW, default 0; 1 inverts every output (a-g, dp) for common-anode displays.
REQ-002 Parameter HEX_MODE, default 1; 1 decodes 10-15 as A,b,C,d,E,F; 0 blanks codes 10-15 and lights dp as an error flag.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 w  input  1  code bit 3 (MSB).
REQ-006 x  input  1  code bit 2.
REQ-007 y  input  1  code bit 1.
REQ-008 z  input  1  code bit 0 (LSB).
REQ-009 a,b,c,d,e,f,g  output  1 each  segments top, upper-right, lower-right, bottom, lower-left, upper-left, middle.
REQ-010 dp  output  1  decimal point.

Function
REQ-011 Nibble N = {w,x,y,z} SHALL be sampled on each rising clk edge.
REQ-012 Outputs SHALL be registered; the pattern for N SHALL appear on the output one clock edge after N is sampled (1-cycle latency), with no combinational path from inputs to outputs.
REQ-013 Logical (active-high) pattern abcdefg SHALL be:
- 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
- 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
REQ-014 With HEX_MODE=1, logical patterns SHALL be A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111, with logical dp=0.
REQ-015 With HEX_MODE=0, codes 10-15 SHALL produce logical abcdefg=0000000 and logical dp=1; codes 0-9 SHALL produce logical dp=0.
REQ-016 Physical output SHALL equal the logical value when ACTIVE_LOW=0 and its inverse when ACTIVE_LOW=1.
REQ-017 Input changes every cycle SHALL be tracked without loss; each input value maps to exactly one output cycle.
REQ-018 Code wrap 15->0 SHALL need no special handling; the output follows the table.
REQ-019 The block SHALL have no other state; outputs depend only on the last sampled nibble, or on reset.

Reset
REQ-020 While rst=1 at a rising edge, all segments and dp SHALL go to the inactive level: 0 when ACTIVE_LOW=0, 1 when ACTIVE_LOW=1.
REQ-021 Reset SHALL take priority over decoding.
REQ-022 A nibble presented during the reset cycle SHALL be discarded.
REQ-023 The first valid pattern SHALL appear one edge after rst deasserts.
REQ-024 Reset asserted mid-stream SHALL blank the outputs at the next edge.

Structure
REQ-025 Package seven_seg_pkg SHALL hold the 16 seven-bit segment-pattern constants, the blank pattern, and the segment bit-order definition (bit 6=a ... bit 0=g).
REQ-026 One combinational sub-module, seven_seg_decode (nibble plus HEX_MODE in, logical abcdefg and dp out), SHALL be instantiated by seven_seg.
REQ-027 seven_seg itself SHALL contain the input/output registers, the polarity inversion and the reset.

Verification
REQ-028 Reset: rst=1 for 2 cycles with N=8 (ACTIVE_LOW=0) -> abcdefg=0000000 and dp=0 throughout; one edge after release, abcdefg=1111111.
REQ-029 Exhaustive sweep: N stepped 0..15, one code per cycle, as a binary counter (z toggling fastest, w slowest) -> each output matches REQ-013/014 exactly one cycle later (e.g. N=2 -> 1101101, N=0xA -> 1110111).
REQ-030 Wrap: N=15 then N=0 on consecutive cycles -> 1000111 then 1111110, with no glitch cycle between.
REQ-031 HEX_MODE=0: N=12 -> abcdefg=0000000 and dp=1; N=9 -> 1111011 and dp=0.
REQ-032 ACTIVE_LOW=1: reset -> all outputs 1; N=1 -> abcdefg=1001111 and dp=1.
REQ-033 Mid-stream reset: sweep running, rst pulsed for 1 cycle at N=5 -> outputs blank for that cycle; the next code decodes normally one edge later.
